tiled_mac_accumulator: RTL

- Output-stationary matrix multiply-accumulate over a stream of K-tiles: D[M][N] = C + sum over tiles of A_t*B_t.
- Sits between the operand streamer and the result writer; it replaces single-shot MAC with on-chip accumulation across tiles.
- Supports a runtime packed 4-bit mode and saturating accumulation as a compile option.
- Elastic valid/ready on both sides with a configurable multiplier pipeline depth.

---
 rtl/tiled_mac_pkg.sv | 36 +++
 rtl/tiled_mac_accumulator_dot.sv | 34 +++
 rtl/tiled_mac_accumulator.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tiled_mac_pkg.sv
// tiled_mac_pkg: shared types and arithmetic helpers for tiled_mac_accumulator.
// Contents: FSM state enum, accumulator width helper, sign-extension and
// saturating-add helpers (operate on 64-bit containers, valid for widths <= 63).
package tiled_mac_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} mac_state_e;

    function automatic int acc_width(input int p);
        return 4 * p;
    endfunction

    function automatic logic signed [63:0] sext(input logic [63:0] x, input int w);
        return $signed(x << (64 - w)) >>> (64 - w);
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] x, input logic signed [63:0] y, input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        s = x + y;
        hi = sat_max(w);
        return s > hi ? hi : (s < -hi - 64'sd1 ? -hi - 64'sd1 : s);
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] x, input logic signed [63:0] y, input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        s = x + y;
        hi = sat_max(w);
        return s > hi || s < -hi - 64'sd1;
    endfunction

endpackage

// File: rtl/tiled_mac_accumulator_dot.sv
// dot_product_lane: combinational K-way signed dot product of one A row and one B column.
// Ports: a/b = K operands of P bits, halved = packed 4-bit mode (two signed P/2 lanes
// per operand, hi*hi + lo*lo), dot = sum sign-extended to ACC_W bits.
module dot_product_lane #(
    parameter int K = 4,
    parameter int P = 8,
    parameter int ACC_W = 32
) (
    input  logic [K-1:0][P-1:0]      a,
    input  logic [K-1:0][P-1:0]      b,
    input  logic                     halved,
    output logic signed [ACC_W-1:0]  dot
);

    // Padded to a power of two so the adder tree halves cleanly each level.
    localparam int NT = 2 ** $clog2(2 * K);

    logic signed [ACC_W-1:0] t [NT];

    always_comb begin
        for (int i = 0; i < NT; i++) t[i] = '0;
        for (int k = 0; k < K; k++) begin
            t[2*k]   = halved ? ACC_W'($signed(a[k][P-1:P/2])) * ACC_W'($signed(b[k][P-1:P/2]))
                              : ACC_W'($signed(a[k])) * ACC_W'($signed(b[k]));
            t[2*k+1] = halved ? ACC_W'($signed(a[k][P/2-1:0])) * ACC_W'($signed(b[k][P/2-1:0])) : '0;
        end
        for (int s = 1; s < NT; s = s * 2)
            for (int i = 0; i < NT; i += 2 * s)
                t[i] = t[i] + t[i+s];
    end

    assign dot = t[0];

endmodule

// File: rtl/tiled_mac_accumulator.sv
// tiled_mac_accumulator: output-stationary D = C + sum_t A_t*B_t over a stream of K-tiles.
// Inputs: clk_i, rst_ni (sync, active-high), a_i/b_i tiles, c_i initial accumulator,
// first_i/last_i group framing, halved_i packed mode, valid_i/ready_o input handshake.
// Outputs: d_o/valid_o result with ready_i backpressure, busy_o, tile_count_o.
// Build option TILED_MAC_SATURATE_EN: saturating accumulation plus sat_o flag.
module tiled_mac_accumulator
    import tiled_mac_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 2,
    parameter int K = 4,
    parameter int P = 8,
    parameter int PIPESTAGES = 2,
    parameter int CNT_W = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic signed [M-1:0][K-1:0][P-1:0]    a_i,
    input  logic signed [K-1:0][N-1:0][P-1:0]    b_i,
    input  logic signed [M-1:0][N-1:0][4*P-1:0]  c_i,
    input  logic                                 first_i,
    input  logic                                 last_i,
    input  logic                                 halved_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    output logic signed [M-1:0][N-1:0][4*P-1:0] d_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic                                 busy_o,
`ifdef TILED_MAC_SATURATE_EN
    output logic                                 sat_o,
`endif
    output logic [CNT_W-1:0]                     tile_count_o
);

    localparam int ACC_W = acc_width(P);
    localparam int DW = M * N * ACC_W;
    localparam int PW = 2 * DW + 2;
    localparam int S = PIPESTAGES - 1;

    // Input side tracks group framing so the mode can be latched on the
    // effective first beat (an unframed beat after a group end starts a group).
    logic in_grp, mode_q, eff_first, mode, accept;
    logic [DW-1:0] dot_flat;
    logic [PW-1:0] in_pay, head_pay;
    logic head_valid, acc_ready, pipe_busy;

    assign eff_first = first_i || !in_grp;
    assign mode = eff_first ? halved_i : mode_q;
    assign accept = valid_i && ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            in_grp <= 1'b0;
            mode_q <= 1'b0;
        end else if (accept) begin
            in_grp <= !last_i;
            mode_q <= mode;
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [K-1:0][P-1:0] col;
            for (genvar k = 0; k < K; k++) begin : g_k
                assign col[k] = b_i[k][j];
            end
            dot_product_lane #(.K(K), .P(P), .ACC_W(ACC_W)) u_lane (
                .a(a_i[i]),
                .b(col),
                .halved(mode),
                .dot(dot_flat[(i*N+j)*ACC_W +: ACC_W])
            );
        end
    end

    assign in_pay = {eff_first, last_i, c_i, dot_flat};

    if (S == 0) begin : g_direct
        assign head_valid = valid_i;
        assign head_pay = in_pay;
        assign ready_o = acc_ready;
        assign pipe_busy = 1'b0;
    end else begin : g_pipe
        logic [S-1:0] vld, vin;
        logic [PW-1:0] pay [S];
        logic [PW-1:0] pin [S];
        logic rdy [S+1];
        // A stage loads whenever it is empty or its content moves on this cycle.
        always_comb begin
            vin = S'({vld, valid_i});
            pin[0] = in_pay;
            for (int j = 1; j < S; j++) pin[j] = pay[j-1];
            rdy[S] = acc_ready;
            for (int j = S - 1; j >= 0; j--) rdy[j] = !vld[j] || rdy[j+1];
        end
        always_ff @(posedge clk_i) begin
            if (rst_ni) vld <= '0;
            else for (int j = 0; j < S; j++) if (rdy[j]) vld[j] <= vin[j];
        end
        always_ff @(posedge clk_i) begin
            for (int j = 0; j < S; j++) if (rdy[j]) pay[j] <= pin[j];
        end
        assign head_valid = vld[S-1];
        assign head_pay = pay[S-1];
        assign ready_o = rdy[0];
        assign pipe_busy = |vld;
    end

    mac_state_e state;
    logic h_first, h_last, take, start;
    logic [DW-1:0] h_c, h_dot;
    logic signed [M-1:0][N-1:0][ACC_W-1:0] nxt;
    logic [ACC_W-1:0] base;
`ifdef TILED_MAC_SATURATE_EN
    logic hit;
    logic signed [63:0] s64;
`endif

    assign {h_first, h_last, h_c, h_dot} = head_pay;
    assign acc_ready = state != DRAIN || ready_i;
    assign take = head_valid && acc_ready;
    assign start = h_first || state != ACCUM;

    always_comb begin
        nxt = '0;
        base = '0;
`ifdef TILED_MAC_SATURATE_EN
        hit = 1'b0;
        s64 = '0;
`endif
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                base = start ? h_c[(i*N+j)*ACC_W +: ACC_W] : d_o[i][j];
`ifdef TILED_MAC_SATURATE_EN
                s64 = sat_add(sext(64'(base), ACC_W), sext(64'(h_dot[(i*N+j)*ACC_W +: ACC_W]), ACC_W), ACC_W);
                hit = hit | sat_hit(sext(64'(base), ACC_W), sext(64'(h_dot[(i*N+j)*ACC_W +: ACC_W]), ACC_W), ACC_W);
                nxt[i][j] = s64[ACC_W-1:0];
`else
                nxt[i][j] = base + h_dot[(i*N+j)*ACC_W +: ACC_W];
`endif
            end
        end
    end

    // A beat arriving in DRAIN is only taken together with the consume, so
    // it always starts a new group.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state <= IDLE;
            d_o <= '0;
            tile_count_o <= '0;
`ifdef TILED_MAC_SATURATE_EN
            sat_o <= 1'b0;
`endif
        end else if (take) begin
            state <= h_last ? DRAIN : ACCUM;
            d_o <= nxt;
            tile_count_o <= start ? CNT_W'(1) : tile_count_o + CNT_W'(tile_count_o != '1);
`ifdef TILED_MAC_SATURATE_EN
            sat_o <= (sat_o && !start) || hit;
`endif
        end else if (state == DRAIN && ready_i) begin
            state <= IDLE;
            tile_count_o <= '0;
        end
    end

    assign valid_o = state == DRAIN;
    assign busy_o = state != IDLE || pipe_busy;

endmodule
